// File: rtl/rtc_bus_pkg.sv
// Shared state codes, default timing and strobe window helper for the RTC bus sequencer.
// Burst mode elsewhere is enabled with RTC_BUS_BURST_EN.
package rtc_bus_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_CNT_W     = 5;
  localparam int DEF_T_PHASE   = 22;
  localparam int DEF_T_AD_OFF  = 19;
  localparam int DEF_T_CS_ON   = 2;
  localparam int DEF_T_CS_OFF  = 17;
  localparam int DEF_T_STB_ON  = 3;
  localparam int DEF_T_STB_OFF = 16;
  localparam int DEF_T_GAP     = 2;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t ADDR = 3'd1;
  localparam state_t GAP  = 3'd2;
  localparam state_t DATA = 3'd3;
  localparam state_t DONE = 3'd4;

  function automatic logic inWindow(input int cnt, input int lo, input int hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/rtc_bus_sequencer_timer.sv
// Phase counter with window decode; outputs are raw active-low windows, gated by the FSM.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_AD_OFF  = DEF_T_AD_OFF,
  parameter int T_CS_ON   = DEF_T_CS_ON,
  parameter int T_CS_OFF  = DEF_T_CS_OFF,
  parameter int T_STB_ON  = DEF_T_STB_ON,
  parameter int T_STB_OFF = DEF_T_STB_OFF
) (
  input  logic             clkW,
  input  logic             resetAD,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             csN,
  output logic             stbN,
  output logic             adN
);

  always_ff @(posedge clkW) begin
    if (resetAD || clr) count <= '0;
    else                count <= count + 1'b1;
  end

  assign adN  = !inWindow(int'(count), 0, T_AD_OFF - 1);
  assign csN  = !inWindow(int'(count), T_CS_ON, T_CS_OFF);
  assign stbN = !inWindow(int'(count), T_STB_ON, T_STB_OFF);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed address/data bus sequencer: ADDR, GAP, DATA per beat, then DONE.
// Define RTC_BUS_BURST_EN to add the burst_len port and multi-beat bursts.
//
// state | meaning
// IDLE  | waiting for start with enW=1
// ADDR  | drive address, AD/CS/WR windows
// GAP   | all strobes high, bus released
// DATA  | write: drive data with WR window; read: RD window, sample bus_in
// DONE  | one cycle, done=1, start ignored
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int T_PHASE   = DEF_T_PHASE,
  parameter int T_AD_OFF  = DEF_T_AD_OFF,
  parameter int T_CS_ON   = DEF_T_CS_ON,
  parameter int T_CS_OFF  = DEF_T_CS_OFF,
  parameter int T_STB_ON  = DEF_T_STB_ON,
  parameter int T_STB_OFF = DEF_T_STB_OFF,
  parameter int T_GAP     = DEF_T_GAP
) (
  input  logic              clkW,
  input  logic              resetAD,
  input  logic              enW,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] bus_out,
  input  logic [DATA_W-1:0] bus_in,
  output logic              bus_oe,
  output logic              CS,
  output logic              RD,
  output logic              WR,
  output logic              AD
`ifdef RTC_BUS_BURST_EN
  ,
  input  logic [3:0]        burst_len
`endif
);

  state_t            state, stateNext;
  logic [CNT_W-1:0]  count;
  logic              phaseClr;
  logic              csWinN, stbWinN, adWinN;
  logic [DATA_W-1:0] addrQ, wrDataQ;
  logic              rwQ;
  logic [3:0]        beatsLeft;
  logic [3:0]        burstLen;

`ifdef RTC_BUS_BURST_EN
  assign burstLen = burst_len;
`else
  assign burstLen = '0;
`endif

  rtc_phase_timer #(
    .CNT_W(CNT_W), .T_AD_OFF(T_AD_OFF), .T_CS_ON(T_CS_ON), .T_CS_OFF(T_CS_OFF),
    .T_STB_ON(T_STB_ON), .T_STB_OFF(T_STB_OFF)
  ) uTimer (
    .clkW(clkW), .resetAD(resetAD), .clr(phaseClr), .count(count),
    .csN(csWinN), .stbN(stbWinN), .adN(adWinN)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (start && enW) stateNext = ADDR;
      ADDR: if (count == CNT_W'(T_PHASE - 1)) stateNext = GAP;
      GAP:  if (count == CNT_W'(T_GAP - 1)) stateNext = DATA;
      DATA: if (count == CNT_W'(T_PHASE - 1)) stateNext = (beatsLeft == '0) ? DONE : ADDR;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Counter restarts on every state entry, including DATA->ADDR between beats.
  assign phaseClr = (stateNext != state) || (state == IDLE);

  always_ff @(posedge clkW) begin
    if (resetAD) begin
      state     <= IDLE;
      addrQ     <= '0;
      wrDataQ   <= '0;
      rwQ       <= 1'b0;
      beatsLeft <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      CS        <= 1'b1;
      RD        <= 1'b1;
      WR        <= 1'b1;
      AD        <= 1'b1;
    end else begin
      state    <= stateNext;
      busy     <= (stateNext != IDLE);
      done     <= (stateNext == DONE);
      rd_valid <= 1'b0;

      if (state == IDLE && stateNext == ADDR) begin
        addrQ     <= addr;
        rwQ       <= rw;
        beatsLeft <= burstLen;
      end
      if (state == DATA && stateNext == ADDR) begin
        addrQ     <= addrQ + 1'b1;
        beatsLeft <= beatsLeft - 1'b1;
      end
      if (state == ADDR && count == '0) wrDataQ <= wr_data;
      if (state == DATA && rwQ && count == CNT_W'(T_STB_OFF)) begin
        rd_data  <= bus_in;
        rd_valid <= 1'b1;
      end

      // Registered strobes trail the count by one cycle.
      AD     <= (state != ADDR) || adWinN;
      CS     <= !(state == ADDR || state == DATA) || csWinN;
      WR     <= !(state == ADDR || (state == DATA && !rwQ)) || stbWinN;
      RD     <= !(state == DATA && rwQ) || stbWinN;
      bus_oe <= (state == ADDR) || (state == DATA && !rwQ);
      if (state == ADDR)             bus_out <= addrQ;
      else if (state == DATA && !rwQ) bus_out <= wrDataQ;
      else                           bus_out <= '0;
    end
  end

endmodule
